pet_prg_loader: RTL and testbench

PRG injection sequencer for the PET core's DMA port into the 32 KB main RAM. It accepts a `.PRG` byte stream (2-byte little-endian load address followed by program bytes) and stalls the CPU for the duration. It writes the payload through the `dma_addr`/`dma_din`/`dma_we` port of `pet2001hw` and, for BASIC programs, patches the BASIC 4 end-of-program pointers so `RUN` works immediately. It sits between the download interface and `pet2001hw`; `cpu_hold` drives `clk_stop`.

---
 rtl/pet_pkg.sv | 20 ++
 rtl/pet_prg_loader.sv | 184 ++++++++++++++++++
 tb/tb_pet_prg_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pet_pkg.sv
// pet_pkg: shared types and constants for the PET PRG loader.
// Holds the loader FSM state enum and RAM / BASIC 4 pointer defaults.
package pet_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_DRAIN,
    S_PTRS,
    S_RELEASE
  } loader_state_t;

  localparam logic [15:0] PET_RAM_TOP     = 16'h7FFF;
  localparam logic [7:0]  PET_VARTAB      = 8'h2A;
  localparam logic [15:0] PET_BASIC_START = 16'h0401;

endpackage

// File: rtl/pet_prg_loader.sv
// pet_prg_loader: stalls the CPU, streams a .PRG into RAM over DMA,
// patches VARTAB/ARYTAB/STREND for BASIC loads; all outputs registered.
module pet_prg_loader
  import pet_pkg::*;
#(
  parameter logic [15:0] BASIC_START = PET_BASIC_START,
  parameter logic [7:0]  PTR_BASE    = PET_VARTAB
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        hold_ack,
  output logic        cpu_hold,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        busy,
  output logic        done,
  output logic        error
);

  loader_state_t state_q, state_d;
  logic [15:0] load_q, load_d;
  logic [15:0] ptr_q, ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        in_ready_q, in_ready_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        dma_we_q, dma_we_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic [7:0]  dma_din_q, dma_din_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        xfer;
  logic [15:0] hdr_load;
  logic [7:0]  ptr_off;

  assign xfer     = in_valid && in_ready_q;
  assign hdr_load = {in_data, load_q[7:0]};
  assign ptr_off  = PTR_BASE + {5'd0, cnt_q};

  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    cpu_hold_d = cpu_hold_q;
    dma_we_d   = 1'b0;
    dma_addr_d = dma_addr_q;
    dma_din_d  = dma_din_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d    = 1'b0;
          busy_d     = 1'b1;
          cpu_hold_d = 1'b1;
          cnt_d      = 3'd0;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_ack) state_d = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (xfer) begin
          load_d[7:0] = in_data;
          if (in_last) begin
            error_d = 1'b1;
            state_d = S_RELEASE;
          end else begin
            state_d = S_HDR_HI;
          end
        end
      end
      S_HDR_HI: begin
        if (xfer) begin
          load_d = hdr_load;
          ptr_d  = hdr_load;
          if (hdr_load[15]) begin
            error_d = 1'b1;
            state_d = in_last ? S_RELEASE : S_DRAIN;
          end else if (in_last) begin
            state_d = S_PTRS;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        // ptr never has bit 15 set here: reaching 7FFF with
        // more bytes pending diverts to DRAIN before 8000.
        if (xfer) begin
          dma_we_d   = 1'b1;
          dma_addr_d = ptr_q;
          dma_din_d  = in_data;
          ptr_d      = ptr_q + 16'd1;
          if (in_last) begin
            state_d = S_PTRS;
          end else if (ptr_q == PET_RAM_TOP) begin
            error_d = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (xfer && in_last) state_d = S_RELEASE;
      end
      S_PTRS: begin
        if (load_q != BASIC_START || error_q) begin
          state_d = S_RELEASE;
        end else begin
          // even count -> low byte, odd -> high byte
          dma_we_d   = 1'b1;
          dma_addr_d = {8'h00, ptr_off};
          dma_din_d  = cnt_q[0] ? ptr_q[15:8] : ptr_q[7:0];
          if (cnt_q == 3'd5) begin
            cnt_d   = 3'd0;
            state_d = S_RELEASE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_RELEASE: begin
        cpu_hold_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_HDR_LO) || (state_d == S_HDR_HI) ||
                 (state_d == S_DATA)   || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      load_q     <= 16'h0000;
      ptr_q      <= 16'h0000;
      cnt_q      <= 3'd0;
      in_ready_q <= 1'b0;
      cpu_hold_q <= 1'b0;
      dma_we_q   <= 1'b0;
      dma_addr_q <= 16'h0000;
      dma_din_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      cpu_hold_q <= cpu_hold_d;
      dma_we_q   <= dma_we_d;
      dma_addr_q <= dma_addr_d;
      dma_din_q  <= dma_din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready = in_ready_q;
  assign cpu_hold = cpu_hold_q;
  assign dma_we   = dma_we_q;
  assign dma_addr = dma_addr_q;
  assign dma_din  = dma_din_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_pet_prg_loader.sv
// tb_pet_prg_loader: randomized .PRG loads against a byte-level model
// of the expected RAM writes, error flag and done pulse.
module tb_pet_prg_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        hold_ack;
  logic        cpu_hold;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_we;
  logic        busy;
  logic        done;
  logic        error;

  pet_prg_loader dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .hold_ack (hold_ack),
    .cpu_hold (cpu_hold),
    .dma_addr (dma_addr),
    .dma_din  (dma_din),
    .dma_we   (dma_we),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  logic [7:0]  stim[$];
  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];
  bit          exp_err;
  int          done_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (dma_we) begin
        got_q.push_back({dma_addr, dma_din});
        chk("rom_guard", {31'd0, dma_addr[15]}, 32'd0);
      end
      if (done) begin
        done_cnt++;
        chk("done_rel", {30'd0, busy, cpu_hold}, 32'd0);
      end
    end
  end

  // Reference: what RAM writes a .PRG stream should produce.
  task automatic build_model();
    int p;
    int ld;
    exp_q.delete();
    exp_err = 1'b0;
    if (stim.size() < 2) begin
      exp_err = 1'b1;
    end else begin
      ld = int'(stim[1]) * 256 + int'(stim[0]);
      if (ld >= 32768) begin
        exp_err = 1'b1;
      end else begin
        p = ld;
        for (int i = 2; i < stim.size(); i++) begin
          if (p >= 32768) begin
            exp_err = 1'b1;
            break;
          end
          exp_q.push_back({p[15:0], stim[i]});
          p++;
        end
        if (!exp_err && ld == 16'h0401) begin
          for (int k = 0; k < 3; k++) begin
            exp_q.push_back({16'h002A + 16'(2 * k), p[7:0]});
            exp_q.push_back({16'h002B + 16'(2 * k), p[15:8]});
          end
        end
      end
    end
  endtask

  task automatic run_load(input int stall, input int vpct,
                          input bit poke);
    int idx;
    int cyc;
    bit acc;
    got_q.delete();
    done_cnt = 0;
    build_model();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    chk("hold_rise", {31'd0, cpu_hold}, 32'd1);
    repeat (stall) begin
      chk("stall_rdy", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    hold_ack = 1'b1;
    @(posedge clk); #1;
    chk("rdy_rise", {31'd0, in_ready}, 32'd1);
    idx = 0;
    cyc = 0;
    while (idx < stim.size() && cyc < 4000) begin
      in_valid = ($urandom_range(99) < vpct);
      in_data  = stim[idx];
      in_last  = (idx == stim.size() - 1);
      if (poke && cyc == 3) start = 1'b1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("stream_to", idx, stim.size());
    cyc = 0;
    while (busy && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("busy_to", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    hold_ack = 1'b0;
    chk("nwr", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("wr", {8'd0, got_q[i]}, {8'd0, exp_q[i]});
    chk("error", {31'd0, error}, {31'd0, exp_err});
    chk("done_cnt", done_cnt, 1);
  endtask

  task automatic reset_mid_data();
    int idx;
    stim = '{8'h00, 8'h20, 8'h10, 8'h11, 8'h12, 8'h13,
             8'h14, 8'h15, 8'h16, 8'h17};
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    hold_ack = 1'b1;
    @(posedge clk); #1;
    idx = 0;
    while (idx < 5) begin
      in_valid = 1'b1;
      in_data  = stim[idx];
      @(posedge clk); #1;
      if (in_ready) idx++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async",
        {2'd0, in_ready, cpu_hold, dma_we, dma_addr, dma_din,
         busy, done, error}, 32'd0);
    in_valid = 1'b0;
    hold_ack = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ign", {30'd0, busy, cpu_hold}, 32'd0);
    got_q.delete();
  endtask

  initial begin
    int mode;
    int len;
    logic [15:0] ld;
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    hold_ack = 1'b0;
    done_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vals",
        {2'd0, in_ready, cpu_hold, dma_we, dma_addr, dma_din,
         busy, done, error}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_vals",
        {2'd0, in_ready, cpu_hold, dma_we, busy, done, error},
        32'd0);

    stim = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    run_load(20, 100, 1'b0);
    chk("basic_first", {8'd0, got_q.size() > 0 ? got_q[0] : 24'd0},
        32'h0401AA);
    chk("basic_vartab", {8'd0, got_q.size() > 3 ? got_q[3] : 24'd0},
        32'h002A04);

    stim = '{8'h00, 8'h10, 8'h11, 8'h22, 8'h33};
    run_load(2, 60, 1'b0);

    stim = '{8'hFE, 8'h7F, 8'h01, 8'h02, 8'h03, 8'h04};
    run_load(0, 100, 1'b0);

    stim = '{8'h00, 8'h90, 8'h05, 8'h06, 8'h07};
    run_load(1, 70, 1'b0);

    stim = '{8'h01};
    run_load(0, 100, 1'b0);

    stim = '{8'h01, 8'h04};
    run_load(3, 50, 1'b0);

    stim = '{8'h00, 8'h05, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    run_load(0, 50, 1'b1);

    reset_mid_data();

    stim = '{8'h01, 8'h04, 8'h99};
    run_load(0, 100, 1'b0);

    for (int t = 0; t < 14; t++) begin
      mode = $urandom_range(3);
      case (mode)
        0: ld = 16'h0401;
        1: ld = 16'($urandom_range(16'h7FF0));
        2: ld = 16'h7FF8 + 16'($urandom_range(7));
        default: ld = 16'h8000 | 16'($urandom_range(16'h7FFF));
      endcase
      len = $urandom_range(12);
      stim.delete();
      stim.push_back(ld[7:0]);
      stim.push_back(ld[15:8]);
      for (int i = 0; i < len; i++)
        stim.push_back(8'($urandom_range(255)));
      run_load($urandom_range(5), $urandom_range(100, 30), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
